jam_cost_table: RTL and testbench
=================================

# jam_cost_table

Cost-matrix responder for the Job Assignment Machine: it holds the 8x8 worker/job cost table and answers the JAM's W/J lookups with Cost. The table is loaded once through a ready/valid stream. While loading, the block computes a row-minimum lower bound for the total cost. After loading, it counts service cycles until the JAM raises Valid. It sits between the testbench/host loader and the JAM core, replacing the behavioural cost ROM.

## Interface
Parameters:
- COST_W, 7, cost word width
- CNT_W, 20, service-cycle counter width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- Clear  in  1  synchronous restart into LOAD
- LoadValid  in  1  load word present
- LoadData  in  COST_W  cost word, row-major (worker-major), entry 8*w+j
- LoadReady  out  1  block accepts a load word
- W  in  3  worker index from JAM
- J  in  3  job index from JAM
- Cost  out  COST_W  table[8*W+J]
- Ready  out  1  table fully loaded
- LowerBound  out  10  sum over rows of row minimum
- JamValid  in  1  JAM result-valid strobe
- CycleCount  out  CNT_W  cycles spent in SERVE
- Done  out  1  JamValid seen; count frozen

## Operation
- States: LOAD, SERVE, DONE. RST -> LOAD.
- LOAD:
  - LoadReady=1.
  - A load beat is LoadValid&&LoadReady. Each beat writes table[ptr] and increments the 6-bit ptr.
  - The beat that writes ptr==63 moves the state to SERVE. ptr wraps to 0.
- Row-minimum accumulation in LOAD:
  - rowmin is set to LoadData when ptr[2:0]==0. Otherwise it becomes min(rowmin, LoadData).
  - On the beat with ptr[2:0]==7, the accumulator adds min(rowmin, LoadData), zero-extended to 10 bits. Max sum 8*127=1016, so no overflow.
  - LowerBound shows the accumulator and is valid when Ready=1.
- SERVE:
  - Cost = table[{W,J}], combinational from registered storage.
  - CycleCount increments by 1 every SERVE cycle and saturates at 2^CNT_W-1.
  - JamValid moves the state to DONE. The cycle carrying JamValid is not counted.
- DONE:
  - Done=1; CycleCount holds.
  - Cost is still served.
  - JamValid is ignored.
- LOAD-state outputs: Cost=0, Ready=0. LoadData is ignored outside LOAD.
- Clear (any state, priority over all other inputs):
  - Next state LOAD; ptr, rowmin, accumulator, CycleCount and Done are zeroed.
  - Table contents are not erased. They are overwritten by the reload.
- JamValid during LOAD is ignored.

## Timing
- Reset values: LoadReady=1, Ready=0, Cost=0, LowerBound=0, CycleCount=0, Done=0; all table entries 0.
- Load: one word per cycle at full throughput. 64 beats minimum. Ready rises on the edge that captures beat 64.
- Lookup: zero-cycle latency. Cost is valid in the same cycle W/J settle, before the next rising edge.
- First SERVE cycle: CycleCount=0, becoming 1 after that edge.
- JamValid at edge N: Done=1 and CycleCount frozen from edge N onward.
- RST mid-load: all progress is lost, and the state returns to LOAD at ptr 0 immediately (asynchronous).
- Clear together with a load beat: the beat is discarded.

## Structure
- Shared package jam_pkg holds the state enum (LOAD/SERVE/DONE), COST_W, TABLE_DEPTH=64, and LB_W=10. The JAM core reuses COST_W.
- One natural sub-module: jam_cost_loader. It contains the ptr counter, row-min and accumulator logic, and a write-enable/address output.
- The table array, lookup mux, cycle counter and top FSM stay in jam_cost_table.

## Test plan
- Reset, then 64 beats with LoadData=(8w+j)%128 (entry 8w+j) -> Ready rises after beat 64; W=3,J=5 gives Cost=29; LowerBound = 0+8+16+…+56 = 224.
- Load with LoadValid toggled 1/0 each cycle -> 64 accepted words in 127 cycles; table identical to the unthrottled load.
- All entries 127 except the diagonal at 1 -> LowerBound=8; W=2,J=2 gives Cost=1; W=2,J=3 gives Cost=127.
- After load, hold 100 cycles, then pulse JamValid -> CycleCount=100, Done=1; count unchanged 50 cycles later; a second JamValid has no effect.
- Clear asserted at beat 30 of a load -> Ready=0, ptr restarts at 0; a full 64-beat reload with new data -> Cost and LowerBound reflect only the new data.
- Assert RST asynchronously mid-SERVE (between edges) -> Ready=0, Cost=0, CycleCount=0, LoadReady=1 immediately.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared definitions for the Job Assignment Machine cost-table slice.
// The JAM core reuses COST_W; the table block uses the rest.
package jam_pkg;

  localparam int COST_W      = 7;
  localparam int TABLE_DEPTH = 64;
  localparam int PTR_W       = $clog2(TABLE_DEPTH);
  localparam int LB_W        = 10;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Row-major table index: worker selects the row, job the column.
  function automatic logic [PTR_W-1:0] tbl_idx(input logic [2:0] w, input logic [2:0] j);
    return {w, j};
  endfunction

endpackage

// File: rtl/jam_cost_table_if.sv
// Loader/JAM-facing signal bundle of the cost table; slave is the table side.
// Port names follow the existing JAM core so it can connect without renaming.
interface jam_cost_table_if #(
  parameter int COST_W = 7,
  parameter int CNT_W  = 20
);

  logic                     Clear;
  logic                     LoadValid;
  logic [COST_W-1:0]        LoadData;
  logic                     LoadReady;
  logic [2:0]               W;
  logic [2:0]               J;
  logic [COST_W-1:0]        Cost;
  logic                     Ready;
  logic [jam_pkg::LB_W-1:0] LowerBound;
  logic                     JamValid;
  logic [CNT_W-1:0]         CycleCount;
  logic                     Done;

  modport master (
    output Clear, LoadValid, LoadData, W, J, JamValid,
    input  LoadReady, Cost, Ready, LowerBound, CycleCount, Done
  );

  modport slave (
    input  Clear, LoadValid, LoadData, W, J, JamValid,
    output LoadReady, Cost, Ready, LowerBound, CycleCount, Done
  );

endinterface

// File: rtl/jam_cost_loader.sv
// Load-stream sequencer: write pointer, table write strobe and row-minimum lower bound.
// A beat is accepted by the caller; clear_i wins over a same-cycle beat.
module jam_cost_loader #(
  parameter int COST_W = 7
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      clear_i,
  input  logic                      beat_i,
  input  logic [COST_W-1:0]         data_i,
  output logic                      we_o,
  output logic [jam_pkg::PTR_W-1:0] waddr_o,
  output logic [COST_W-1:0]         wdata_o,
  output logic                      last_o,
  output logic [jam_pkg::LB_W-1:0]  lb_o
);
  import jam_pkg::*;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [COST_W-1:0] rowmin_q, rowmin_d;
  logic [LB_W-1:0]   acc_q, acc_d;
  logic [COST_W-1:0] cur_min;
  logic              row_first;
  logic              row_last;

  assign row_first = (ptr_q[2:0] == 3'd0);
  assign row_last  = (ptr_q[2:0] == 3'd7);

  // Minimum of the current row including the word on the bus this cycle.
  assign cur_min = (row_first || (data_i < rowmin_q)) ? data_i : rowmin_q;

  always_comb begin
    ptr_d    = ptr_q;
    rowmin_d = rowmin_q;
    acc_d    = acc_q;
    if (clear_i) begin
      ptr_d    = '0;
      rowmin_d = '0;
      acc_d    = '0;
    end else if (beat_i) begin
      ptr_d    = ptr_q + PTR_W'(1);
      rowmin_d = cur_min;
      if (row_last) begin
        acc_d = acc_q + LB_W'(cur_min);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q    <= '0;
      rowmin_q <= '0;
      acc_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rowmin_q <= rowmin_d;
      acc_q    <= acc_d;
    end
  end

  assign we_o    = beat_i && !clear_i;
  assign waddr_o = ptr_q;
  assign wdata_o = data_i;
  assign last_o  = we_o && (ptr_q == PTR_W'(TABLE_DEPTH - 1));
  assign lb_o    = acc_q;

endmodule

// File: rtl/jam_cost_table.sv
// 8x8 worker/job cost table for the JAM: streamed load, zero-latency lookup, service-cycle count.
// Load accepts one word per cycle while in LOAD; Clear restarts loading from entry 0.
module jam_cost_table #(
  parameter int COST_W = 7,
  parameter int CNT_W  = 20
) (
  input logic             CLK,
  input logic             RST,
  jam_cost_table_if.slave bus
);
  import jam_pkg::*;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [COST_W-1:0] table_q [TABLE_DEPTH];

  logic              in_load;
  logic              beat;
  logic              tbl_we;
  logic [PTR_W-1:0]  tbl_waddr;
  logic [COST_W-1:0] tbl_wdata;
  logic              load_last;
  logic [LB_W-1:0]   lb;

  assign in_load = (state_q == LOAD);
  assign beat    = bus.LoadValid && in_load;

  jam_cost_loader #(
    .COST_W (COST_W)
  ) u_loader (
    .CLK     (CLK),
    .RST     (RST),
    .clear_i (bus.Clear),
    .beat_i  (beat),
    .data_i  (bus.LoadData),
    .we_o    (tbl_we),
    .waddr_o (tbl_waddr),
    .wdata_o (tbl_wdata),
    .last_o  (load_last),
    .lb_o    (lb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD: begin
        if (load_last) state_d = SERVE;
      end
      SERVE: begin
        // The cycle that carries JamValid is not part of the service time.
        if (bus.JamValid) begin
          state_d = DONE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
    if (bus.Clear) begin
      state_d = LOAD;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Contents survive Clear; a reload overwrites every entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < TABLE_DEPTH; i++) table_q[i] <= '0;
    end else if (tbl_we) begin
      table_q[tbl_waddr] <= tbl_wdata;
    end
  end

  assign bus.LoadReady  = in_load;
  assign bus.Ready      = !in_load;
  assign bus.Cost       = in_load ? '0 : table_q[tbl_idx(bus.W, bus.J)];
  assign bus.LowerBound = lb;
  assign bus.CycleCount = cnt_q;
  assign bus.Done       = (state_q == DONE);

endmodule

// File: tb/tb_jam_cost_table.sv
// Directed + randomized bench for jam_cost_table against an array-based reference table.
module tb_jam_cost_table;

  logic CLK;
  logic RST;

  jam_cost_table_if #(.COST_W(7), .CNT_W(20)) bus ();

  jam_cost_table #(.COST_W(7), .CNT_W(20)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0] ref_tbl [64];
  logic [6:0] stim    [64];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_lb();
    int s = 0;
    for (int w = 0; w < 8; w++) begin
      int m = ref_tbl[8*w];
      for (int j = 1; j < 8; j++) if (ref_tbl[8*w+j] < m) m = ref_tbl[8*w+j];
      s += m;
    end
    return s;
  endfunction

  // mode 0: every cycle valid; 1: valid toggles 1/0; 2: random valid.
  task automatic load_stream(input int mode, input bit jam_noise, output int ncyc);
    int k = 0;
    bit v;
    ncyc = 0;
    while (k < 64 && ncyc < 2000) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (ncyc % 2 == 0);
      else                v = 1'($urandom_range(0, 1));
      bus.LoadValid = v;
      bus.LoadData  = stim[k];
      bus.JamValid  = jam_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (v && k == 63) chk("ready_before_last_beat", 32'(bus.Ready), 0);
      @(posedge CLK); #1;
      ncyc++;
      if (v) begin
        ref_tbl[k] = stim[k];
        k++;
      end
    end
    bus.LoadValid = 1'b0;
    bus.JamValid  = 1'b0;
    bus.LoadData  = 7'($urandom);
    chk("load_beats_accepted", 32'(k), 64);
    chk("ready_after_load", 32'(bus.Ready), 1);
    chk("loadready_after_load", 32'(bus.LoadReady), 0);
    chk("count_first_serve", 32'(bus.CycleCount), 0);
  endtask

  task automatic check_all();
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        bus.W = 3'(w);
        bus.J = 3'(j);
        #1;
        chk($sformatf("cost_w%0d_j%0d", w, j), 32'(bus.Cost), 32'(ref_tbl[8*w+j]));
      end
    end
    chk("lower_bound_model", 32'(bus.LowerBound), 32'(ref_lb()));
  endtask

  task automatic lookup(input string tag, input int w, input int j, input int exp);
    bus.W = 3'(w);
    bus.J = 3'(j);
    #1;
    chk(tag, 32'(bus.Cost), 32'(exp));
  endtask

  task automatic do_clear();
    bus.Clear = 1'b1;
    @(posedge CLK); #1;
    bus.Clear = 1'b0;
  endtask

  initial begin
    int ncyc;
    RST           = 1'b1;
    bus.Clear     = 1'b0;
    bus.LoadValid = 1'b0;
    bus.LoadData  = '0;
    bus.W         = '0;
    bus.J         = '0;
    bus.JamValid  = 1'b0;
    for (int i = 0; i < 64; i++) ref_tbl[i] = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_loadready", 32'(bus.LoadReady), 1);
    chk("rst_ready", 32'(bus.Ready), 0);
    chk("rst_cost", 32'(bus.Cost), 0);
    chk("rst_lowerbound", 32'(bus.LowerBound), 0);
    chk("rst_cyclecount", 32'(bus.CycleCount), 0);
    chk("rst_done", 32'(bus.Done), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Ramp pattern at full rate
    for (int i = 0; i < 64; i++) stim[i] = 7'(i % 128);
    load_stream(0, 1'b0, ncyc);
    chk("ramp_cycles", 32'(ncyc), 64);
    lookup("ramp_w3_j5", 3, 5, 29);
    chk("ramp_lowerbound", 32'(bus.LowerBound), 224);
    check_all();

    // Random data, random throttle, JamValid noise during load
    do_clear();
    chk("clear_ready", 32'(bus.Ready), 0);
    chk("clear_lowerbound", 32'(bus.LowerBound), 0);
    for (int i = 0; i < 64; i++) stim[i] = 7'($urandom);
    load_stream(2, 1'b1, ncyc);
    check_all();

    // Ramp again, valid toggling 1/0
    do_clear();
    for (int i = 0; i < 64; i++) stim[i] = 7'(i % 128);
    load_stream(1, 1'b0, ncyc);
    chk("toggle_cycles", 32'(ncyc), 127);
    check_all();

    // Diagonal 1, rest 127; then service-cycle count
    do_clear();
    for (int i = 0; i < 64; i++) stim[i] = (i / 8 == i % 8) ? 7'd1 : 7'd127;
    load_stream(0, 1'b0, ncyc);
    bus.LoadValid = 1'b1;
    repeat (100) @(posedge CLK);
    #1;
    chk("serve_count_100", 32'(bus.CycleCount), 100);
    chk("serve_not_done", 32'(bus.Done), 0);
    bus.JamValid = 1'b1;
    @(posedge CLK); #1;
    bus.JamValid = 1'b0;
    chk("jam_count_frozen", 32'(bus.CycleCount), 100);
    chk("jam_done", 32'(bus.Done), 1);
    repeat (50) @(posedge CLK);
    #1;
    chk("done_count_hold", 32'(bus.CycleCount), 100);
    bus.JamValid = 1'b1;
    @(posedge CLK); #1;
    bus.JamValid  = 1'b0;
    bus.LoadValid = 1'b0;
    chk("second_jam_count", 32'(bus.CycleCount), 100);
    chk("second_jam_done", 32'(bus.Done), 1);
    chk("diag_lowerbound", 32'(bus.LowerBound), 8);
    lookup("diag_w2_j2", 2, 2, 1);
    lookup("diag_w2_j3", 2, 3, 127);
    check_all();

    // Clear together with beat 30, then full reload with new data
    do_clear();
    chk("clear_from_done", 32'(bus.Done), 0);
    for (int i = 0; i < 30; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = 7'($urandom);
      @(posedge CLK); #1;
      ref_tbl[i] = bus.LoadData;
    end
    bus.Clear     = 1'b1;
    bus.LoadData  = 7'($urandom);
    @(posedge CLK); #1;
    bus.Clear     = 1'b0;
    bus.LoadValid = 1'b0;
    chk("midload_clear_ready", 32'(bus.Ready), 0);
    chk("midload_clear_loadready", 32'(bus.LoadReady), 1);
    chk("midload_clear_lowerbound", 32'(bus.LowerBound), 0);
    for (int i = 0; i < 64; i++) stim[i] = 7'($urandom);
    load_stream(2, 1'b0, ncyc);
    check_all();

    // Asynchronous reset between edges while serving
    repeat (5) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_ready", 32'(bus.Ready), 0);
    chk("arst_cost", 32'(bus.Cost), 0);
    chk("arst_cyclecount", 32'(bus.CycleCount), 0);
    chk("arst_loadready", 32'(bus.LoadReady), 1);
    chk("arst_lowerbound", 32'(bus.LowerBound), 0);
    chk("arst_done", 32'(bus.Done), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
